// File: rtl/uart_frame_rx_pkg.sv
// Shared types and constants for the UART frame receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP1  = 3'd4,
    ST_STOP2  = 3'd5
  } rx_state_t;

  localparam logic [1:0] PAR_NONE     = 2'd0;
  localparam logic [1:0] PAR_EVEN     = 2'd1;
  localparam logic [1:0] PAR_ODD      = 2'd2;
  localparam logic [1:0] PAR_NONE_ALT = 2'd3;

  localparam int OVS    = 16;
  localparam int SMP_LO = 6;
  localparam int SMP_HI = 11;
  localparam int DECIDE = 12;

  // Index of the last data bit for a data_bits code (5..8 bits -> 4..7).
  function automatic logic [2:0] last_bit_idx(input logic [1:0] data_bits);
    return 3'd4 + {1'b0, data_bits};
  endfunction

  function automatic logic parity_on(input logic [1:0] mode);
    case (mode)
      PAR_EVEN, PAR_ODD:     return 1'b1;
      PAR_NONE, PAR_NONE_ALT: return 1'b0;
      default:               return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_frame_rx_if.sv
// Received-word handshake bundle between the UART receiver and its consumer.
interface uart_frame_rx_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       parity_err;
  logic       frame_err;
  logic       break_det;
  logic       overrun;

  modport master (
    output rx_data, rx_valid, parity_err, frame_err, break_det, overrun,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, parity_err, frame_err, break_det, overrun,
    output rx_ready
  );
endinterface

// File: rtl/uart_ovs_tick.sv
// Oversample tick generator: one tick every max(baud_div,2) clocks while enabled.
module uart_ovs_tick #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] baud_div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] reload;

  // Down-counter cycles 0, div-1 .. 1; tick fires at terminal count 1.
  assign reload = (baud_div < DIV_W'(2)) ? DIV_W'(1) : baud_div - DIV_W'(1);
  assign tick   = en && (cnt_q == DIV_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (!en) begin
      cnt_q <= '0;
    end else if (cnt_q == '0) begin
      cnt_q <= reload;
    end else begin
      cnt_q <= cnt_q - DIV_W'(1);
    end
  end

endmodule

// File: rtl/uart_frame_rx.sv
// UART frame receiver: 16x oversampling, majority decision, 5-8 data bits,
// optional parity, one or two stop bits, single-word output buffer.
//
// state     | meaning
// ----------+---------------------------------------------------
// ST_IDLE   | line idle, waiting for a start edge
// ST_START  | validating the start bit (false starts abort here)
// ST_DATA   | shifting data bits in, LSB first
// ST_PARITY | receiving the parity bit
// ST_STOP1  | first stop bit
// ST_STOP2  | second stop bit (only when stop2 latched high)
module uart_frame_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50000000,
  parameter int DIV_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] baud_div,
  input  logic [1:0]       data_bits,
  input  logic [1:0]       parity_mode,
  input  logic             stop2,
  input  logic             rx_pin,
  uart_frame_rx_if.master  rx_if,
  output logic             rx_busy
);

  // CLK_FREQ only documents the intended clock; nothing is derived from it.
  if (CLK_FREQ < 1) begin : g_clk_freq_invalid
  end

  rx_state_t  state_q, state_d;
  logic [2:0] sync_q;
  logic       rx_s, start_edge;
  logic       tick;
  logic [3:0] tick_cnt_q;
  logic [2:0] smp_sum_q, bit_cnt_q;
  logic [7:0] shreg_q;
  logic       par_acc_q, par_q, stop1_q;
  logic [1:0] cfg_bits_q, cfg_par_q;
  logic       cfg_stop2_q;

  logic       smp_en, dec, bit_end, bit_dec, start_false, par_en, frame_done;
  logic       stop1_v, perr_v, ferr_v, brk_v;

  logic [7:0] rx_data_q;
  logic       rx_valid_q, parity_err_q, frame_err_q, break_det_q, overrun_q;

  assign rx_s       = sync_q[1];
  assign start_edge = sync_q[2] & ~sync_q[1];

  uart_ovs_tick #(.DIV_W(DIV_W)) u_tick (
    .clk      (clk),
    .rst      (rst),
    .en       (state_q != ST_IDLE),
    .baud_div (baud_div),
    .tick     (tick)
  );

  assign smp_en      = tick && (tick_cnt_q >= 4'(SMP_LO)) && (tick_cnt_q <= 4'(SMP_HI));
  assign dec         = tick && (tick_cnt_q == 4'(DECIDE));
  assign bit_end     = tick && (tick_cnt_q == 4'(OVS - 1));
  assign bit_dec     = smp_sum_q >= 3'd4;
  assign start_false = smp_sum_q >= 3'd3;
  assign par_en      = parity_on(cfg_par_q);
  assign frame_done  = dec && (((state_q == ST_STOP1) && !cfg_stop2_q) || (state_q == ST_STOP2));

  assign stop1_v = (state_q == ST_STOP1) ? bit_dec : stop1_q;
  assign ferr_v  = !stop1_v || ((state_q == ST_STOP2) && !bit_dec);
  assign perr_v  = par_en && (par_acc_q ^ par_q ^ (cfg_par_q == PAR_ODD));
  assign brk_v   = (shreg_q == 8'h00) && !(par_en && par_q) && !stop1_v;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start_edge) state_d = ST_START;
      ST_START: begin
        if (dec && start_false) state_d = ST_IDLE;
        else if (bit_end)       state_d = ST_DATA;
      end
      ST_DATA: begin
        if (bit_end && (bit_cnt_q == last_bit_idx(cfg_bits_q)))
          state_d = par_en ? ST_PARITY : ST_STOP1;
      end
      ST_PARITY: if (bit_end) state_d = ST_STOP1;
      ST_STOP1: begin
        if (dec && !cfg_stop2_q) state_d = ST_IDLE;
        else if (bit_end)        state_d = ST_STOP2;
      end
      ST_STOP2:  if (dec) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q      <= 3'b111;
      tick_cnt_q  <= '0;
      smp_sum_q   <= '0;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      par_acc_q   <= 1'b0;
      par_q       <= 1'b0;
      stop1_q     <= 1'b0;
      cfg_bits_q  <= '0;
      cfg_par_q   <= '0;
      cfg_stop2_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], rx_pin};
      if (state_q == ST_IDLE) begin
        tick_cnt_q <= '0;
        smp_sum_q  <= '0;
        if (start_edge) begin
          cfg_bits_q  <= data_bits;
          cfg_par_q   <= parity_mode;
          cfg_stop2_q <= stop2;
          bit_cnt_q   <= '0;
          shreg_q     <= '0;
          par_acc_q   <= 1'b0;
          par_q       <= 1'b0;
          stop1_q     <= 1'b0;
        end
      end else if (tick) begin
        tick_cnt_q <= tick_cnt_q + 4'd1;
        if (smp_en)  smp_sum_q <= smp_sum_q + {2'b00, rx_s};
        if (bit_end) smp_sum_q <= '0;
        if (dec) begin
          case (state_q)
            ST_DATA: begin
              shreg_q[bit_cnt_q] <= bit_dec;
              par_acc_q          <= par_acc_q ^ bit_dec;
            end
            ST_PARITY: par_q   <= bit_dec;
            ST_STOP1:  stop1_q <= bit_dec;
            default: ;
          endcase
        end
        if (bit_end && (state_q == ST_DATA)) bit_cnt_q <= bit_cnt_q + 3'd1;
      end
    end
  end

  // A completing word wins over a same-cycle handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      break_det_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else if (frame_done) begin
      rx_data_q    <= shreg_q;
      rx_valid_q   <= 1'b1;
      parity_err_q <= perr_v;
      frame_err_q  <= ferr_v;
      break_det_q  <= brk_v;
      if (rx_valid_q) overrun_q <= !rx_if.rx_ready;
    end else if (rx_valid_q && rx_if.rx_ready) begin
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
    end
  end

  assign rx_if.rx_data    = rx_data_q;
  assign rx_if.rx_valid   = rx_valid_q;
  assign rx_if.parity_err = parity_err_q;
  assign rx_if.frame_err  = frame_err_q;
  assign rx_if.break_det  = break_det_q;
  assign rx_if.overrun    = overrun_q;
  assign rx_busy          = state_q != ST_IDLE;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed bench for uart_frame_rx with a scoreboard of expected words.
module tb_uart_frame_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] baud_div;
  logic [1:0]  data_bits;
  logic [1:0]  parity_mode;
  logic        stop2;
  logic        rx_pin;
  logic        rx_busy;

  uart_frame_rx_if rx_if ();

  uart_frame_rx #(.CLK_FREQ(50000000), .DIV_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .baud_div    (baud_div),
    .data_bits   (data_bits),
    .parity_mode (parity_mode),
    .stop2       (stop2),
    .rx_pin      (rx_pin),
    .rx_if       (rx_if),
    .rx_busy     (rx_busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    logic       brk;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   valid_rises = 0;
  logic prev_valid = 1'b0;

  always @(posedge clk) begin
    prev_valid <= rx_if.rx_valid;
    if (rx_if.rx_valid && !prev_valid) valid_rises <= valid_rises + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bit_time(input logic v);
    rx_pin = v;
    repeat (16 * int'(baud_div)) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d, input int nb, input logic [1:0] pm,
                      input bit flip, input bit two_stop, input bit s2v, input bit scramble);
    logic [7:0] dm;
    logic       pbit;
    exp_t       e;
    dm          = d & 8'((1 << nb) - 1);
    pbit        = (^dm) ^ (pm == 2'd2) ^ flip;
    e.data      = dm;
    e.perr      = (pm == 2'd1 || pm == 2'd2) && flip;
    e.ferr      = two_stop && !s2v;
    e.brk       = 1'b0;
    sb.push_back(e);
    data_bits   = 2'(nb - 5);
    parity_mode = pm;
    stop2       = two_stop;
    @(negedge clk);
    rx_pin = 1'b0;
    repeat (8 * int'(baud_div)) @(negedge clk);
    if (scramble) begin
      data_bits   = 2'd0;
      parity_mode = 2'd0;
      stop2       = 1'b1;
    end
    repeat (8 * int'(baud_div)) @(negedge clk);
    for (int i = 0; i < nb; i++) bit_time(dm[i]);
    if (pm == 2'd1 || pm == 2'd2) bit_time(pbit);
    bit_time(1'b1);
    if (two_stop) bit_time(s2v);
    rx_pin = 1'b1;
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n = 0;
    while (rx_if.rx_valid !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, rx_if.rx_valid, 1'b1);
  endtask

  task automatic check_word(input string tag);
    exp_t e;
    check({tag, "_sb_nonempty"}, sb.size() != 0, 1'b1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_data"}, rx_if.rx_data, e.data);
      check({tag, "_parity_err"}, rx_if.parity_err, e.perr);
      check({tag, "_frame_err"}, rx_if.frame_err, e.ferr);
      check({tag, "_break_det"}, rx_if.break_det, e.brk);
    end
  endtask

  task automatic handshake(input string tag);
    @(negedge clk);
    rx_if.rx_ready = 1'b1;
    @(negedge clk);
    rx_if.rx_ready = 1'b0;
    check({tag, "_valid_dropped"}, rx_if.rx_valid, 1'b0);
    check({tag, "_overrun_clear"}, rx_if.overrun, 1'b0);
  endtask

  initial begin
    int base;
    rst            = 1'b1;
    rx_pin         = 1'b1;
    rx_if.rx_ready = 1'b0;
    baud_div       = 16'd27;
    data_bits      = 2'd3;
    parity_mode    = 2'd0;
    stop2          = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", rx_if.rx_valid, 1'b0);
    check("rst_data", rx_if.rx_data, 8'h00);
    check("rst_parity_err", rx_if.parity_err, 1'b0);
    check("rst_frame_err", rx_if.frame_err, 1'b0);
    check("rst_break_det", rx_if.break_det, 1'b0);
    check("rst_overrun", rx_if.overrun, 1'b0);
    check("rst_busy", rx_busy, 1'b0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // 8N1 0xA5 at divisor 27
    send(8'hA5, 8, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_valid("a5", 2000);
    check_word("a5");
    check("a5_overrun", rx_if.overrun, 1'b0);
    handshake("a5");

    baud_div = 16'd8;
    repeat (10) @(negedge clk);

    // 7E1 with the parity bit flipped
    send(8'h41, 7, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0);
    wait_valid("7e1_bad", 600);
    check_word("7e1_bad");
    handshake("7e1_bad");

    // 7O1, correct parity, config inputs disturbed mid-frame
    send(8'h41, 7, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1);
    wait_valid("7o1_latch", 600);
    check_word("7o1_latch");
    handshake("7o1_latch");

    // 5N1: unused MSBs must read zero
    send(8'hFB, 5, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_valid("5n1", 600);
    check_word("5n1");
    handshake("5n1");

    // 8N2 with the second stop bit low
    send(8'h3C, 8, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    wait_valid("8n2_ferr", 600);
    check_word("8n2_ferr");
    handshake("8n2_ferr");
    repeat (32 * int'(baud_div)) @(negedge clk);

    // break: 12 bit times of low line on 8N1
    data_bits   = 2'd3;
    parity_mode = 2'd0;
    stop2       = 1'b0;
    sb.push_back('{data: 8'h00, perr: 1'b0, ferr: 1'b1, brk: 1'b1});
    @(negedge clk);
    rx_pin = 1'b0;
    repeat (12 * 16 * int'(baud_div)) @(negedge clk);
    rx_pin = 1'b1;
    wait_valid("break", 600);
    check_word("break");
    handshake("break");
    repeat (32 * int'(baud_div)) @(negedge clk);

    // 4-tick glitch: false start
    rx_pin = 1'b0;
    repeat (4 * int'(baud_div)) @(negedge clk);
    rx_pin = 1'b1;
    repeat (4) @(negedge clk);
    check("glitch_busy_high", rx_busy, 1'b1);
    repeat (16 * int'(baud_div)) @(negedge clk);
    check("glitch_busy_low", rx_busy, 1'b0);
    check("glitch_no_valid", rx_if.rx_valid, 1'b0);

    // overrun: two words without a handshake
    send(8'h11, 8, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    send(8'h22, 8, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_valid("ovr", 600);
    check("ovr_overrun_set", rx_if.overrun, 1'b1);
    check("ovr_sb_depth", sb.size(), 2);
    if (sb.size() == 2) void'(sb.pop_front());
    check_word("ovr");
    handshake("ovr");

    // reset during data bit 3 of 0x5A, then a clean 0x5A
    data_bits = 2'd3;
    @(negedge clk);
    bit_time(1'b0);
    bit_time(1'b0);
    bit_time(1'b1);
    bit_time(1'b0);
    rx_pin = 1'b1;
    repeat (8 * int'(baud_div)) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_busy", rx_busy, 1'b0);
    check("midrst_valid", rx_if.rx_valid, 1'b0);
    rst = 1'b0;
    repeat (32 * int'(baud_div)) @(negedge clk);
    base = valid_rises;
    send(8'h5A, 8, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_valid("post_rst", 600);
    check_word("post_rst");
    repeat (16 * int'(baud_div)) @(negedge clk);
    check("post_rst_single_valid", valid_rises - base, 1);
    handshake("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_frame_rx.md
UART_FRAME_RX -- requirements
Module: uart_frame_rx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50000000, system clock frequency in Hz (documentation and bench use only).
REQ-002 SHALL have parameter DIV_W, default 16, width of the runtime baud divisor.
REQ-003 SHALL have port clk, input, 1, single system clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port baud_div, input, DIV_W, clk cycles per oversample tick (16 ticks per bit).
REQ-006 SHALL have port data_bits, input, 2, data length: 0=5, 1=6, 2=7, 3=8.
REQ-007 SHALL have port parity_mode, input, 2, parity mode: 0=none, 1=even, 2=odd, 3=none.
REQ-008 SHALL have port stop2, input, 1, stop bits: 0=one, 1=two.
REQ-009 SHALL have port rx_pin, input, 1, asynchronous serial line, idle high.
REQ-010 SHALL have port rx_data, output, 8, received word, LSB first, unused MSBs zero.
REQ-011 SHALL have port rx_valid, output, 1, word available; held until consumed.
REQ-012 SHALL have port rx_ready, input, 1, consumer accepts the word when rx_valid=1 and rx_ready=1.
REQ-013 SHALL have ports parity_err, frame_err and break_det, outputs, 1 each, status of the presented word, qualified by rx_valid.
REQ-014 SHALL have port overrun, output, 1, sticky flag: a word was lost; cleared by a handshake.
REQ-015 SHALL have port rx_busy, output, 1, high while not in IDLE.

Function
REQ-016 SHALL pass rx_pin through a 3-flop synchronizer and detect the start edge as previous=1, current=0 on the last two flops.
REQ-017 SHALL generate one tick every max(baud_div,2) clk cycles while not IDLE; the tick counter is held at 0 in IDLE.
REQ-018 SHALL use a 16-tick bit period, sample at ticks 6..11 (six samples), and decide each bit at tick 12: 1 if sum>=4, else 0.
REQ-019 SHALL implement the FSM IDLE -> START -> DATA -> [PARITY] -> STOP1 -> [STOP2] -> IDLE; PARITY only when parity_mode is 1 or 2, STOP2 only when stop2=1.
REQ-020 SHALL abort to IDLE at tick 12 of START when the start sum is >=3 (false start), with no rx_valid and no flag change.
REQ-021 SHALL latch data_bits, parity_mode and stop2 on start-edge detection; changes mid-frame have no effect on the current frame.
REQ-022 SHALL shift DATA bits in LSB first, for exactly data_bits+5 bits.
REQ-023 SHALL set parity_err when the XOR of the data bits and the parity bit is 1 (even mode) or 0 (odd mode).
REQ-024 SHALL set frame_err when any stop-bit decision is 0.
REQ-025 SHALL set break_det when all data bits, the parity bit (if present) and stop bit 1 are 0; frame_err is also 1 in that case.
REQ-026 SHALL, on the final stop-bit decision, load rx_data and the flags and raise rx_valid on the next clk, then return to IDLE in the same cycle so a start edge arriving during the final stop bit's ticks 13..15 is accepted.
REQ-027 SHALL drop rx_valid in the cycle after the handshake.
REQ-028 SHALL, when a new word completes while rx_valid=1, overwrite rx_data and the flags, keep rx_valid=1, and set overrun.
REQ-029 SHALL give precedence to the new word's load over a handshake in the same cycle; overrun stays clear in that case.
REQ-030 SHALL treat baud_div changes as valid only while rx_busy=0.

Reset
REQ-031 SHALL, on rst=1, asynchronously set FSM=IDLE, all counters 0, synchronizer flops 1, rx_data=0, and rx_valid, parity_err, frame_err, break_det, overrun and rx_busy to 0.
REQ-032 SHALL abandon any frame in progress on reset mid-frame and produce no output from it.

Structure
REQ-033 SHALL place the state enum, the parity-mode encodings and the constants OVS=16, SMP_LO=6, SMP_HI=11, DECIDE=12 in the shared package uart_pkg.
REQ-034 SHALL place tick generation in sub-module uart_ovs_tick (inputs clk, rst, en, baud_div; output tick).

Verification
REQ-035 SHALL cover: baud_div=27, 8N1, byte 0xA5 -> rx_data=0xA5, rx_valid=1, all flags 0.
REQ-036 SHALL cover: 7E1, data 0x41, parity bit flipped -> rx_data=0x41, parity_err=1, frame_err=0.
REQ-037 SHALL cover: 8N2 with second stop bit 0 -> frame_err=1; 8N1 with 12-bit-time low line -> rx_data=0x00, break_det=1, frame_err=1.
REQ-038 SHALL cover: a low glitch of 4 ticks on an idle line -> false-start abort, rx_valid stays 0, rx_busy returns to 0.
REQ-039 SHALL cover: rx_ready=0, bytes 0x11 then 0x22 -> rx_data=0x22, overrun=1; one handshake -> rx_valid=0, overrun=0.
REQ-040 SHALL cover: rst pulse at DATA bit 3, then byte 0x5A -> single rx_valid carrying 0x5A.
